// File: rtl/mdc8p_pkg.sv
// Shared constants, bit-reversal helper and read-FSM encoding for the
// 8-point MDC FFT output reorder buffer.
package mdc8p_pkg;

  localparam int FFT_N   = 8;
  localparam int N_PAIRS = 4;
  localparam int LOG2_N  = 3;

  // Natural index -> bit-reversed index for a 3-bit address.
  localparam logic [LOG2_N-1:0] BITREV3_TAB [FFT_N] = '{
    3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7
  };

  function automatic logic [LOG2_N-1:0] bitrev3(input logic [LOG2_N-1:0] a);
    return BITREV3_TAB[a];
  endfunction

  // Read-FSM state encoding.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

endpackage

// File: rtl/mdc8p_reorder_bank.sv
// Ping-pong frame store: two banks of FFT_N complex words, two write ports
// into the write bank and two combinational read ports from the read bank.
module mdc8p_reorder_bank
  import mdc8p_pkg::*;
#(
  parameter int NB_WORD = 24
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic                wr_bank_i,
  input  logic [LOG2_N-1:0]   wr_addr1_i,
  input  logic [LOG2_N-1:0]   wr_addr2_i,
  input  logic [NB_WORD-1:0]  wr_data1_i,
  input  logic [NB_WORD-1:0]  wr_data2_i,
  input  logic                rd_bank_i,
  input  logic [LOG2_N-1:0]   rd_addr1_i,
  input  logic [LOG2_N-1:0]   rd_addr2_i,
  output logic [NB_WORD-1:0]  rd_data1_o,
  output logic [NB_WORD-1:0]  rd_data2_o
);

  logic [NB_WORD-1:0] mem_q [2][FFT_N];

  // Store both lanes of a pair; the two lane addresses never collide.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_bank_i][wr_addr1_i] <= wr_data1_i;
      mem_q[wr_bank_i][wr_addr2_i] <= wr_data2_i;
    end
  end

  // Combinational read of the pair being emitted.
  always_comb begin
    rd_data1_o = mem_q[rd_bank_i][rd_addr1_i];
    rd_data2_o = mem_q[rd_bank_i][rd_addr2_i];
  end

endmodule

// File: rtl/mdc8p_reorder.sv
// Output reorder buffer for the 8-point radix-2 MDC FFT: takes bit-reversed
// pairs, emits natural-order pairs (bins 2k, 2k+1) through a ping-pong store.
module mdc8p_reorder
  import mdc8p_pkg::*;
#(
  parameter int NB_DATA = 12
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  input  logic signed [NB_DATA-1:0] i_data1_r,
  input  logic signed [NB_DATA-1:0] i_data1_i,
  input  logic signed [NB_DATA-1:0] i_data2_r,
  input  logic signed [NB_DATA-1:0] i_data2_i,
  output logic                      o_valid,
  output logic                      o_sof,
  output logic signed [NB_DATA-1:0] o_data1_r,
  output logic signed [NB_DATA-1:0] o_data1_i,
  output logic signed [NB_DATA-1:0] o_data2_r,
  output logic signed [NB_DATA-1:0] o_data2_i
);

  localparam int NB_WORD = 2 * NB_DATA;
  localparam logic [LOG2_N-2:0] LAST_PAIR = (LOG2_N-1)'(N_PAIRS - 1);

  logic [LOG2_N-2:0] wr_cnt_q, wr_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic              req_q, req_d;
  logic              req_bank_q, req_bank_d;
  logic [0:0]        state_q, state_d;
  logic [LOG2_N-2:0] rd_cnt_q, rd_cnt_d;
  logic              rd_bank_q, rd_bank_d;
  logic              post, take, rd_en;
  logic [NB_WORD-1:0] rd_word1, rd_word2;

  mdc8p_reorder_bank #(
    .NB_WORD (NB_WORD)
  ) u_bank (
    .clk_i      (i_clk),
    .we_i       (i_valid),
    .wr_bank_i  (wr_bank_q),
    .wr_addr1_i (bitrev3({wr_cnt_q, 1'b0})),
    .wr_addr2_i (bitrev3({wr_cnt_q, 1'b1})),
    .wr_data1_i ({i_data1_r, i_data1_i}),
    .wr_data2_i ({i_data2_r, i_data2_i}),
    .rd_bank_i  (rd_bank_q),
    .rd_addr1_i ({rd_cnt_q, 1'b0}),
    .rd_addr2_i ({rd_cnt_q, 1'b1}),
    .rd_data1_o (rd_word1),
    .rd_data2_o (rd_word2)
  );

  // Write side: pair counter, bank toggle and read-request posting.
  always_comb begin
    post       = i_valid && (wr_cnt_q == LAST_PAIR);
    wr_cnt_d   = i_valid ? wr_cnt_q + 1'b1 : wr_cnt_q;
    wr_bank_d  = post ? ~wr_bank_q : wr_bank_q;
    // A request taken and a new one posted on the same edge both survive.
    req_d      = (req_q && !take) || post;
    req_bank_d = post ? wr_bank_q : req_bank_q;
  end

  // Read FSM: drain a filled bank in 4 cycles, chaining straight into a pending one.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    take      = 1'b0;
    rd_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_q) begin
          state_d   = ST_READ;
          rd_cnt_d  = '0;
          rd_bank_d = req_bank_q;
          take      = 1'b1;
        end
      end
      default: begin
        rd_en    = 1'b1;
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LAST_PAIR) begin
          if (req_q) begin
            rd_cnt_d  = '0;
            rd_bank_d = req_bank_q;
            take      = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      req_q      <= 1'b0;
      req_bank_q <= 1'b0;
      state_q    <= ST_IDLE;
      rd_cnt_q   <= '0;
      rd_bank_q  <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      req_q      <= req_d;
      req_bank_q <= req_bank_d;
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  // Registered outputs; data holds while no pair is being emitted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_sof     <= 1'b0;
      o_data1_r <= '0;
      o_data1_i <= '0;
      o_data2_r <= '0;
      o_data2_i <= '0;
    end else begin
      o_valid <= rd_en;
      o_sof   <= rd_en && (rd_cnt_q == '0);
      if (rd_en) begin
        o_data1_r <= rd_word1[NB_WORD-1:NB_DATA];
        o_data1_i <= rd_word1[NB_DATA-1:0];
        o_data2_r <= rd_word2[NB_WORD-1:NB_DATA];
        o_data2_i <= rd_word2[NB_DATA-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mdc8p_reorder.sv
// Scoreboard bench for mdc8p_reorder: the driver pushes the expected
// natural-order pairs with their due cycle, a monitor pops and compares.
module tb_mdc8p_reorder;

  localparam int NB = 12;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n;
  logic                 i_valid;
  logic signed [NB-1:0] i_data1_r, i_data1_i, i_data2_r, i_data2_i;
  logic                 o_valid, o_sof;
  logic signed [NB-1:0] o_data1_r, o_data1_i, o_data2_r, o_data2_i;

  mdc8p_reorder #(.NB_DATA(NB)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .i_data1_r (i_data1_r),
    .i_data1_i (i_data1_i),
    .i_data2_r (i_data2_r),
    .i_data2_i (i_data2_i),
    .o_valid   (o_valid),
    .o_sof     (o_sof),
    .o_data1_r (o_data1_r),
    .o_data1_i (o_data1_i),
    .o_data2_r (o_data2_r),
    .o_data2_i (o_data2_i)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int                   cyc;
    logic                 sof;
    logic signed [NB-1:0] r1, i1, r2, i2;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   popped  = 0;
  bit   mon_en  = 1'b0;

  // Arrival order of bins: (X0,X4), (X2,X6), (X1,X5), (X3,X7).
  int arr[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int fxr[8];
  int fxi[8];

  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor: compare every presented pair against the scoreboard head.
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (o_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pair cyc=%0d got=(%0d,%0d,%0d,%0d) required=no output",
                   cyc, o_data1_r, o_data1_i, o_data2_r, o_data2_i);
        end else begin
          exp_t e;
          e = q.pop_front();
          popped++;
          if (cyc !== e.cyc) begin
            errors++;
            $display("FAIL pair_timing got_cycle=%0d required_cycle=%0d", cyc, e.cyc);
          end
          checks++;
          if (o_sof !== e.sof) begin
            errors++;
            $display("FAIL sof cyc=%0d got=%0b required=%0b", cyc, o_sof, e.sof);
          end
          checks++;
          if (o_data1_r !== e.r1 || o_data1_i !== e.i1 ||
              o_data2_r !== e.r2 || o_data2_i !== e.i2) begin
            errors++;
            $display("FAIL pair_data cyc=%0d got=(%0d,%0d,%0d,%0d) required=(%0d,%0d,%0d,%0d)",
                     cyc, o_data1_r, o_data1_i, o_data2_r, o_data2_i,
                     e.r1, e.i1, e.r2, e.i2);
          end
        end
      end else begin
        checks++;
        if (o_sof !== 1'b0) begin
          errors++;
          $display("FAIL idle_sof cyc=%0d got=%0b required=0", cyc, o_sof);
        end
      end
    end
  end

  function automatic void check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endfunction

  // Expected output for the frame in fxr/fxi whose last pair lands on edge p.
  task automatic push_frame(input int p);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.cyc = p + 2 + k;
      e.sof = (k == 0);
      e.r1  = NB'(fxr[2*k]);
      e.i1  = NB'(fxi[2*k]);
      e.r2  = NB'(fxr[2*k+1]);
      e.i2  = NB'(fxi[2*k+1]);
      q.push_back(e);
    end
  endtask

  task automatic drive_pair(input int k);
    @(negedge i_clk);
    i_valid   = 1'b1;
    i_data1_r = NB'(fxr[arr[2*k]]);
    i_data1_i = NB'(fxi[arr[2*k]]);
    i_data2_r = NB'(fxr[arr[2*k+1]]);
    i_data2_i = NB'(fxi[arr[2*k+1]]);
    if (k == 3) push_frame(cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
    end
  endtask

  task automatic send_frame();
    for (int k = 0; k < 4; k++) drive_pair(k);
  endtask

  task automatic set_frame(input int base, input int sgn_i);
    for (int n = 0; n < 8; n++) begin
      fxr[n] = base + n;
      fxi[n] = sgn_i * (base + n);
    end
  endtask

  task automatic pulse_reset();
    @(negedge i_clk);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    int target;
    bit reached;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data1_r = '0; i_data1_i = '0; i_data2_r = '0; i_data2_i = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_o_valid", int'(o_valid), 0);
    check("rst_o_sof",   int'(o_sof), 0);
    check("rst_o_data1_r", int'(o_data1_r), 0);
    check("rst_o_data1_i", int'(o_data1_i), 0);
    check("rst_o_data2_r", int'(o_data2_r), 0);
    check("rst_o_data2_i", int'(o_data2_i), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    mon_en  = 1'b1;

    // Single frame: real n, imag -n.
    set_frame(0, -1);
    send_frame();
    idle(8);

    // Six back-to-back frames, real 16f+n.
    for (int f = 0; f < 6; f++) begin
      set_frame(16 * f, -1);
      send_frame();
    end
    idle(8);

    // Gapped input: valid pattern 1,0,0,1,1,0,1.
    set_frame(0, -1);
    drive_pair(0);
    idle(2);
    drive_pair(1);
    drive_pair(2);
    idle(1);
    drive_pair(3);
    idle(8);

    // Extremes in both lanes and both components.
    for (int n = 0; n < 8; n++) begin
      fxr[n] = (n % 2 == 0) ? 2047 : -2048;
      fxi[n] = (n % 2 == 0) ? -2048 : 2047;
    end
    send_frame();
    idle(8);

    // Reset after two pairs of a frame, then a complete frame.
    set_frame(100, -1);
    drive_pair(0);
    drive_pair(1);
    pulse_reset();
    set_frame(200, -1);
    send_frame();
    idle(8);
    drain();

    // Reset during readout after two output pairs.
    set_frame(300, -1);
    target = popped + 2;
    send_frame();
    reached = 1'b0;
    for (int n = 0; n < 50 && !reached; n++) begin
      @(negedge i_clk);
      #1;
      if (popped >= target) reached = 1'b1;
    end
    check("rst_wait_reached", int'(reached), 1);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    q.delete();
    @(posedge i_clk);
    #1;
    check("abort_o_valid", int'(o_valid), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(10);
    set_frame(400, -1);
    send_frame();
    idle(8);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
